// File: rtl/ysyx_25020047_ifu.sv
// rtl/ysyx_25020047_ifu.sv - instruction fetch unit: one fetch per write-back commit
module ysyx_25020047_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_valid,
  input  logic [31:0] i_wb_dnpc,
  output logic        o_imem_arvalid,
  output logic [31:0] o_imem_araddr,
  input  logic        i_imem_arready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic [1:0]  i_imem_rresp,
  output logic        o_imem_rready,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_fault,
  output logic        o_inst_misalign,
  input  logic        i_inst_ready,
  output logic [31:0] o_fetch_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_WAIT_WB = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_fault;
  logic        r_misalign;
  logic [31:0] r_fetch_cnt;

  logic w_handshake;
  logic w_commit;
  logic w_dnpc_misalign;

  assign w_handshake     = (r_state == S_HOLD) && i_inst_ready;
  // A commit in HOLD is only honoured together with the decode handshake.
  assign w_commit        = i_wb_valid && (w_handshake || (r_state == S_WAIT_WB));
  assign w_dnpc_misalign = |i_wb_dnpc[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= NOP_INST;
      r_inst_pc   <= RESET_PC;
      r_fault     <= 1'b0;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else begin
      if (w_handshake) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (i_imem_arready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            r_inst     <= (i_imem_rresp == 2'b00) ? i_imem_rdata : NOP_INST;
            r_fault    <= (i_imem_rresp != 2'b00);
            r_misalign <= 1'b0;
            r_inst_pc  <= r_pc;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD, S_WAIT_WB: begin
          if (w_commit) begin
            r_pc <= i_wb_dnpc;
            // Misaligned targets never reach memory; the fault is reported directly.
            if (w_dnpc_misalign) begin
              r_inst     <= NOP_INST;
              r_fault    <= 1'b1;
              r_misalign <= 1'b1;
              r_inst_pc  <= i_wb_dnpc;
              r_state    <= S_HOLD;
            end else begin
              r_state <= S_REQ;
            end
          end else if (w_handshake) begin
            r_state <= S_WAIT_WB;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_imem_arvalid  = (r_state == S_REQ);
  assign o_imem_araddr   = r_pc;
  assign o_imem_rready   = (r_state == S_WAIT);
  assign o_inst_valid    = (r_state == S_HOLD);
  assign o_inst          = r_inst;
  assign o_inst_pc       = r_inst_pc;
  assign o_inst_fault    = r_fault;
  assign o_inst_misalign = r_misalign;
  assign o_fetch_cnt     = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// tb/tb_ysyx_25020047_ifu.sv - directed self-checking bench for the fetch unit
module tb_ysyx_25020047_ifu;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_dnpc;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_misalign;
  logic        inst_ready;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_25020047_ifu dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wb_valid      (wb_valid),
    .i_wb_dnpc       (wb_dnpc),
    .o_imem_arvalid  (imem_arvalid),
    .o_imem_araddr   (imem_araddr),
    .i_imem_arready  (imem_arready),
    .i_imem_rvalid   (imem_rvalid),
    .i_imem_rdata    (imem_rdata),
    .i_imem_rresp    (imem_rresp),
    .o_imem_rready   (imem_rready),
    .o_inst_valid    (inst_valid),
    .o_inst          (inst),
    .o_inst_pc       (inst_pc),
    .o_inst_fault    (inst_fault),
    .o_inst_misalign (inst_misalign),
    .i_inst_ready    (inst_ready),
    .o_fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b0; wb_dnpc = 32'h0; imem_arready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_rresp = 2'b00; inst_ready = 1'b0;
    tick(); tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_inst got=%h exp=00000013", inst); end
    n_checks++; if (inst_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_inst_pc got=%h exp=80000000", inst_pc); end
    n_checks++; if ({imem_arvalid, imem_rready, inst_fault, inst_misalign} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags got=%b exp=0000", {imem_arvalid, imem_rready, inst_fault, inst_misalign}); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_fetch_cnt got=%h exp=0", fetch_cnt); end
    n_checks++; if (imem_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_araddr got=%h exp=80000000", imem_araddr); end
    // cycle 0 after release
    rst_n = 1'b1; imem_arready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0297;
    tick();
    n_checks++; if (imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL c1_req got=%b/%h exp=1/80000000", imem_arvalid, imem_araddr); end
    tick();
    n_checks++; if (imem_rready !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL c2_wait got=%b/%b exp=1/0", imem_rready, inst_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL c3_inst_valid got=%b exp=1", inst_valid); end
    n_checks++; if (inst !== 32'h0000_0297 || inst_pc !== 32'h8000_0000 || inst_fault !== 1'b0) begin n_fail++; $display("FAIL c3_inst got=%h/%h/%b exp=00000297/80000000/0", inst, inst_pc, inst_fault); end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b1;
    tick();
    n_checks++; if (fetch_cnt !== 32'd1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_cnt got=%h/%b exp=1/0", fetch_cnt, inst_valid); end
    inst_ready = 1'b0; imem_arready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h00a0_0093;
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0010;
    tick();
    wb_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      n_checks++; if (imem_araddr !== 32'h8000_0010) begin n_fail++; $display("FAIL bp_araddr k=%0d got=%h exp=80000010", k, imem_araddr); end
      n_checks++; if (imem_arvalid !== (k <= 4)) begin n_fail++; $display("FAIL bp_arvalid k=%0d got=%b exp=%b", k, imem_arvalid, (k <= 4)); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_early_valid k=%0d got=%b exp=0", k, inst_valid); end
      imem_arready = (k >= 4);
      imem_rvalid  = (k >= 7);
      tick();
    end
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_t8 got=%b exp=1", inst_valid); end
    n_checks++; if (inst !== 32'h00a0_0093 || inst_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL bp_inst got=%h/%h exp=00a00093/80000010", inst, inst_pc); end
  endtask

  task automatic test_misalign();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; wb_valid = 1'b1; wb_dnpc = 32'h8000_0006;
    tick();
    wb_valid = 1'b0;
    n_checks++; if (imem_arvalid !== 1'b0) begin n_fail++; $display("FAIL mis_arvalid got=%b exp=0", imem_arvalid); end
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL mis_inst got=%b/%h exp=1/00000013", inst_valid, inst); end
    n_checks++; if (inst_fault !== 1'b1 || inst_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flags got=%b/%b exp=1/1", inst_fault, inst_misalign); end
    n_checks++; if (inst_pc !== 32'h8000_0006 || fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL mis_pc_cnt got=%h/%h exp=80000006/2", inst_pc, fetch_cnt); end
  endtask

  task automatic test_access_fault();
    inst_ready = 1'b1; wb_valid = 1'b1; wb_dnpc = 32'h8000_0008;
    imem_arready = 1'b1; imem_rvalid = 1'b1; imem_rresp = 2'b10; imem_rdata = 32'hDEAD_BEEF;
    tick();
    inst_ready = 1'b0; wb_valid = 1'b0;
    n_checks++; if (imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0008) begin n_fail++; $display("FAIL af_req got=%b/%h exp=1/80000008", imem_arvalid, imem_araddr); end
    tick(); tick();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL af_inst got=%b/%h exp=1/00000013", inst_valid, inst); end
    n_checks++; if (inst_fault !== 1'b1 || inst_misalign !== 1'b0 || inst_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL af_flags got=%b/%b/%h exp=1/0/80000008", inst_fault, inst_misalign, inst_pc); end
  endtask

  task automatic test_stall_commit();
    imem_rresp = 2'b00; imem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wb_valid = (k == 2); wb_dnpc = 32'h8000_0044;
      tick();
      n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0008 || inst_fault !== 1'b1 || inst_misalign !== 1'b0) begin n_fail++; $display("FAIL stall_hold k=%0d got=%b/%h/%h/%b/%b exp=1/00000013/80000008/1/0", k, inst_valid, inst, inst_pc, inst_fault, inst_misalign); end
    end
    inst_ready = 1'b1; wb_valid = 1'b1; wb_dnpc = 32'h8000_0020;
    tick();
    inst_ready = 1'b0; wb_valid = 1'b0;
    n_checks++; if (imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0020 || fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL sc_req got=%b/%h/%h exp=1/80000020/4", imem_arvalid, imem_araddr, fetch_cnt); end
    tick();
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0100;
    tick();
    wb_valid = 1'b0;
    n_checks++; if (imem_rready !== 1'b1 || inst_valid !== 1'b0 || imem_araddr !== 32'h8000_0020) begin n_fail++; $display("FAIL sc_stray got=%b/%b/%h exp=1/0/80000020", imem_rready, inst_valid, imem_araddr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0517;
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0517 || inst_pc !== 32'h8000_0020) begin n_fail++; $display("FAIL sc_inst got=%b/%h/%h exp=1/00000517/80000020", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_reset_midflight();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; wb_valid = 1'b1; wb_dnpc = 32'h8000_0040; imem_rvalid = 1'b0;
    tick();
    wb_valid = 1'b0;
    tick();
    n_checks++; if (imem_rready !== 1'b1 || fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL mr_in_wait got=%b/%h exp=1/5", imem_rready, fetch_cnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_rready !== 1'b0 || inst_valid !== 1'b0 || fetch_cnt !== 32'd0 || imem_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL mr_async got=%b/%b/%h/%h exp=0/0/0/80000000", imem_rready, inst_valid, fetch_cnt, imem_araddr); end
    tick();
    rst_n = 1'b1; imem_arready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (inst_valid !== 1'b0 || imem_rready !== 1'b0 || fetch_cnt !== 32'd0 || imem_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL mr_stale k=%0d got=%b/%b/%h/%h exp=0/0/0/80000000", k, inst_valid, imem_rready, fetch_cnt, imem_araddr); end
    end
    imem_arready = 1'b1; imem_rvalid = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0297;
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0297 || inst_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL mr_refetch got=%b/%h/%h exp=1/00000297/80000000", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_wrap();
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_cnt;
    #1;
    n_checks++; if (fetch_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preset got=%h exp=ffffffff", fetch_cnt); end
    inst_ready = 1'b1;
    tick();
    n_checks++; if (fetch_cnt !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=00000000", fetch_cnt); end
    inst_ready = 1'b0; wb_valid = 1'b1; wb_dnpc = 32'h8000_0004;
    imem_arready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0093;
    tick();
    wb_valid = 1'b0;
    tick(); tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL wrap_fetch got=%b/%h exp=1/80000004", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_checks++; if (fetch_cnt !== 32'h0000_0001) begin n_fail++; $display("FAIL wrap_one got=%h exp=00000001", fetch_cnt); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_misalign();
    test_access_fault();
    test_stall_commit();
    test_reset_midflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_25020047_ifu.md
# ysyx_25020047_ifu

Instruction fetch unit for the ysyx_25020047 core. It takes the committed next PC (`wb_dnpc`) from the write-back stage and fetches the instruction word at that address over a valid/ready instruction-memory read channel. It presents the fetched word to decode with a valid/ready handshake, then waits for the next write-back commit.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, address of the first fetch after reset
- NOP_INST, 32'h0000_0013, word presented on `inst` when a fetch faults

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  write-back commit strobe, one cycle per retired instruction
- wb_dnpc  in  32  next PC from write-back, sampled when `wb_valid`=1
- imem_arvalid  out  1  read-address request valid
- imem_araddr  out  32  read address, always equals internal pc
- imem_arready  in  1  memory accepts address
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- imem_rresp  in  2  response, 2'b00 = OK, anything else = access fault
- imem_rready  out  1  unit accepts read data
- inst_valid  out  1  instruction available to decode
- inst  out  32  instruction word
- inst_pc  out  32  PC of `inst`
- inst_fault  out  1  fetch faulted (access or misalignment)
- inst_misalign  out  1  fault cause is misaligned PC
- inst_ready  in  1  decode accepts instruction
- fetch_cnt  out  32  count of instructions handed to decode

## Operation
- States: IDLE, REQ, WAIT, HOLD, WAIT_WB.
- IDLE: the state after reset. Moves to REQ unconditionally on the first edge after `rst_n` deasserts.
- REQ: `imem_arvalid`=1. On `imem_arready`=1, moves to WAIT.
- WAIT: `imem_rready`=1, driven combinationally from state. On `imem_rvalid`=1, the unit latches:
  - `inst` = `imem_rdata` when `imem_rresp`==0, else NOP_INST
  - `inst_fault` = (`imem_rresp`!=0)
  - `inst_misalign` = 0
  - next state HOLD
- HOLD: `inst_valid`=1. `inst`, `inst_pc`, `inst_fault` and `inst_misalign` are stable.
  - `inst_ready`=1 alone: moves to WAIT_WB.
  - `inst_ready`=1 and `wb_valid`=1 in the same cycle: the handshake and the commit are both taken. The unit skips WAIT_WB and applies the WAIT_WB commit rule below directly.
- WAIT_WB: on `wb_valid`=1, pc <= `wb_dnpc`.
  - `wb_dnpc[1:0]`!=0: no memory request is issued. Next state HOLD with `inst`=NOP_INST, `inst_fault`=1, `inst_misalign`=1, `inst_pc`=`wb_dnpc`.
  - Otherwise: next state REQ.
- `wb_valid` in IDLE, REQ or WAIT is ignored. In HOLD it is ignored unless `inst_ready`=1 in the same cycle.
- `imem_rvalid` outside WAIT is ignored.
- `imem_araddr` = pc. pc and `imem_arvalid` hold steady from entering REQ until accepted; the unit never withdraws a request.
- `fetch_cnt` increments by 1 on each cycle with `inst_valid` && `inst_ready`. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, `imem_arvalid`=0, `imem_rready`=0, `inst_valid`=0, `inst`=NOP_INST, `inst_pc`=RESET_PC, `inst_fault`=0, `inst_misalign`=0, `fetch_cnt`=0.
- Asserting `rst_n` mid-operation clears all state immediately, whatever the FSM state. A response still in flight after reset is dropped, because `imem_rready`=0 in IDLE and REQ.
- Latency with zero-wait memory (`imem_arready`=1 while requesting, `imem_rvalid` in the first WAIT cycle):
  - `wb_valid` at cycle t gives `imem_arvalid` at t+1, WAIT at t+2, `inst_valid` at t+3.
  - After reset deasserts, `inst_valid` is first high in cycle 3.
- Misaligned commit: `wb_valid` at t gives `inst_valid`=1 with the fault flags set at t+1.
- Memory back-pressure adds cycles one for one: each cycle with `imem_arready`=0 in REQ or `imem_rvalid`=0 in WAIT delays `inst_valid` by one cycle.
- At most one outstanding memory request.

## Test plan
- Reset release, zero-wait memory returning 0x0000_0297 -> `imem_araddr`=0x8000_0000 in cycle 1; `inst_valid`=1, `inst`=0x0000_0297, `inst_pc`=0x8000_0000, `inst_fault`=0 in cycle 3.
- `inst_ready`=1, then `wb_valid`=1 with `wb_dnpc`=0x8000_0010; `imem_arready` held low 3 cycles and `imem_rvalid` delayed 2 cycles -> `imem_araddr` stays stable at 0x8000_0010 throughout; `inst_valid` arrives 5 cycles later than in the zero-wait case; `fetch_cnt`=1.
- `wb_dnpc`=0x8000_0006 -> no `imem_arvalid`; the next cycle shows `inst_valid`=1, `inst`=0x0000_0013, `inst_fault`=1, `inst_misalign`=1, `inst_pc`=0x8000_0006.
- `imem_rresp`=2'b10 with `imem_rdata`=0xDEAD_BEEF -> `inst`=0x0000_0013, `inst_fault`=1, `inst_misalign`=0.
- `inst_ready` held low 4 cycles in HOLD, then `inst_ready`=1 and `wb_valid`=1 in the same cycle with `wb_dnpc`=0x8000_0020 -> outputs stable while stalled; `imem_arvalid`=1 at 0x8000_0020 the next cycle; a stray `wb_valid` during WAIT has no effect.
- `rst_n` pulsed low while in WAIT, stale `imem_rvalid` presented right after release -> `inst_valid` stays 0, `fetch_cnt`=0, the new fetch uses 0x8000_0000. With `fetch_cnt` forced near wrap, 2 handshakes from 0xFFFF_FFFF -> 0x0000_0001.
